// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity modes and default frame parameters.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  localparam int unsigned DEFAULT_DATA_BITS    = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 1;

  // data_xor is the XOR of all data bits; even parity repeats it, odd parity inverts it.
  function automatic logic parity_bit(input logic data_xor, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel word handshake into the UART transmitter.
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS
) ();

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: pulses bit_end on the last clk cycle of every serial bit period.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // With CLKS_PER_BIT = 1 the counter sits at zero and every cycle ends a period.
  assign bit_end = (cnt_q == CntMax);

  // Next count: wrap at the end of a period, hold at zero while cleared.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, data LSB first, optional parity, stop bit(s); line idles high.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned PARITY       = PARITY_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave tx,
  output logic     outgoing_data,
  output logic     busy
);

  localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);
  localparam logic LastStop = 1'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 parity_q, parity_d;
  logic                 line_q, line_d;
  logic                 bit_end;
  logic                 timer_clear;
  logic                 last_stop;
  logic                 accept;

  // Holding the timer cleared in idle aligns the first period with the accept edge.
  assign timer_clear = (state_q == StIdle);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  // Final cycle of the final stop period doubles as an accept slot for gapless frames.
  assign last_stop     = (state_q == StStop) && bit_end && (stop_idx_q == LastStop);
  assign tx.ready      = (state_q == StIdle) || last_stop;
  assign accept        = tx.valid && tx.ready;
  assign busy          = (state_q != StIdle);
  assign outgoing_data = line_q;

  // Next-state, datapath and registered line value.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    parity_d   = parity_q;

    unique case (state_q)
      StIdle: ;
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == LastIdx) begin
            state_d    = (PARITY != PARITY_NONE) ? StParity : StStop;
            stop_idx_d = 1'b0;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + IdxW'(1);
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d    = StStop;
          stop_idx_d = 1'b0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop_idx_q == LastStop) begin
            state_d = StIdle;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Accept only happens in idle or the last stop cycle; it overrides the stop->idle move.
    if (accept) begin
      state_d    = StStart;
      shift_d    = tx.data;
      parity_d   = parity_bit(^tx.data, PARITY);
      bit_idx_d  = '0;
      stop_idx_d = 1'b0;
    end

    unique case (state_d)
      StIdle:   line_d = 1'b1;
      StStart:  line_d = 1'b0;
      StData:   line_d = shift_d[0];
      StParity: line_d = parity_d;
      StStop:   line_d = 1'b1;
      default:  line_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame and drives the line high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      parity_q   <= 1'b0;
      line_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      parity_q   <= parity_d;
      line_q     <= line_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: several parameterisations sharing one clock and reset.
module tb_uart_tx;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  uart_tx_if #(.DATA_BITS(8)) if_def  ();
  uart_tx_if #(.DATA_BITS(8)) if_even ();
  uart_tx_if #(.DATA_BITS(8)) if_odd  ();
  uart_tx_if #(.DATA_BITS(8)) if_slow ();

  logic line_def, line_even, line_odd, line_slow;
  logic busy_def, busy_even, busy_odd, busy_slow;

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(1)) u_def (
    .clk(clk), .reset(reset), .tx(if_def), .outgoing_data(line_def), .busy(busy_def)
  );
  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(1), .PARITY(1), .STOP_BITS(1)) u_even (
    .clk(clk), .reset(reset), .tx(if_even), .outgoing_data(line_even), .busy(busy_even)
  );
  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(1), .PARITY(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .reset(reset), .tx(if_odd), .outgoing_data(line_odd), .busy(busy_odd)
  );
  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u_slow (
    .clk(clk), .reset(reset), .tx(if_slow), .outgoing_data(line_slow), .busy(busy_slow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total += 4;
      if ({line_def, line_even, line_odd, line_slow} !== 4'b1111) begin
        bad++; $display("FAIL reset_line got=%b exp=1111", {line_def, line_even, line_odd, line_slow});
      end
      if ({if_def.ready, if_even.ready, if_odd.ready, if_slow.ready} !== 4'b1111) begin
        bad++; $display("FAIL reset_ready got=%b exp=1111",
                        {if_def.ready, if_even.ready, if_odd.ready, if_slow.ready});
      end
      if ({busy_def, busy_even, busy_odd, busy_slow} !== 4'b0000) begin
        bad++; $display("FAIL reset_busy got=%b exp=0000", {busy_def, busy_even, busy_odd, busy_slow});
      end
      if (u_def.tx.ready !== 1'b1) begin
        bad++; $display("FAIL reset_ready_def got=%b exp=1", u_def.tx.ready);
      end
    end
  endtask

  task automatic test_default;
    logic [9:0] exp;
    exp = {1'b1, 8'hA5, 1'b0};
    @(negedge clk);
    if_def.data  = 8'hA5;
    if_def.valid = 1'b1;
    total++;
    if (if_def.ready !== 1'b1) begin
      bad++; $display("FAIL default_ready_idle got=%b exp=1", if_def.ready);
    end
    @(negedge clk);
    if_def.valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total += 3;
      if (line_def !== exp[i]) begin
        bad++; $display("FAIL default_line[%0d] got=%b exp=%b", i, line_def, exp[i]);
      end
      if (busy_def !== 1'b1) begin
        bad++; $display("FAIL default_busy[%0d] got=%b exp=1", i, busy_def);
      end
      if (if_def.ready !== (i == 9)) begin
        bad++; $display("FAIL default_ready[%0d] got=%b exp=%b", i, if_def.ready, (i == 9));
      end
      @(negedge clk);
    end
    total += 3;
    if (busy_def !== 1'b0) begin
      bad++; $display("FAIL default_busy_end got=%b exp=0", busy_def);
    end
    if (line_def !== 1'b1) begin
      bad++; $display("FAIL default_line_end got=%b exp=1", line_def);
    end
    if (if_def.ready !== 1'b1) begin
      bad++; $display("FAIL default_ready_end got=%b exp=1", if_def.ready);
    end
  endtask

  task automatic test_parity;
    logic [10:0] exp_even;
    logic [10:0] exp_odd;
    // 0xA5 has four ones: even parity bit 0, odd parity bit 1.
    exp_even = {1'b1, 1'b0, 8'hA5, 1'b0};
    exp_odd  = {1'b1, 1'b1, 8'hA5, 1'b0};
    @(negedge clk);
    if_even.data = 8'hA5; if_even.valid = 1'b1;
    if_odd.data  = 8'hA5; if_odd.valid  = 1'b1;
    @(negedge clk);
    if_even.valid = 1'b0; if_odd.valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      total += 3;
      if (line_even !== exp_even[i]) begin
        bad++; $display("FAIL even_a5_line[%0d] got=%b exp=%b", i, line_even, exp_even[i]);
      end
      if (line_odd !== exp_odd[i]) begin
        bad++; $display("FAIL odd_a5_line[%0d] got=%b exp=%b", i, line_odd, exp_odd[i]);
      end
      if (busy_even !== 1'b1) begin
        bad++; $display("FAIL even_busy[%0d] got=%b exp=1", i, busy_even);
      end
      @(negedge clk);
    end
    total++;
    if (busy_even !== 1'b0) begin
      bad++; $display("FAIL even_busy_end got=%b exp=0", busy_even);
    end
    // 0x07 has three ones: even parity bit 1.
    exp_even = {1'b1, 1'b1, 8'h07, 1'b0};
    if_even.data = 8'h07; if_even.valid = 1'b1;
    @(negedge clk);
    if_even.valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      total++;
      if (line_even !== exp_even[i]) begin
        bad++; $display("FAIL even_07_line[%0d] got=%b exp=%b", i, line_even, exp_even[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] exp;
    exp = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
    @(negedge clk);
    if_def.data  = 8'h00;
    if_def.valid = 1'b1;
    @(negedge clk);
    if_def.data = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      total += 3;
      if (line_def !== exp[i]) begin
        bad++; $display("FAIL b2b_line[%0d] got=%b exp=%b", i, line_def, exp[i]);
      end
      if (busy_def !== 1'b1) begin
        bad++; $display("FAIL b2b_busy[%0d] got=%b exp=1", i, busy_def);
      end
      if (if_def.ready !== ((i == 9) || (i == 19))) begin
        bad++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, if_def.ready,
                        ((i == 9) || (i == 19)));
      end
      if (i == 19) if_def.valid = 1'b0;
      @(negedge clk);
    end
    total++;
    if (busy_def !== 1'b0) begin
      bad++; $display("FAIL b2b_busy_end got=%b exp=0", busy_def);
    end
  endtask

  task automatic test_slow_ignore;
    logic [10:0] exp;
    exp = {2'b11, 8'h3C, 1'b0};
    @(negedge clk);
    if_slow.data  = 8'h3C;
    if_slow.valid = 1'b1;
    @(negedge clk);
    if_slow.valid = 1'b0;
    for (int j = 0; j < 44; j++) begin
      total += 3;
      if (line_slow !== exp[j / 4]) begin
        bad++; $display("FAIL slow_line[%0d] got=%b exp=%b", j, line_slow, exp[j / 4]);
      end
      if (busy_slow !== 1'b1) begin
        bad++; $display("FAIL slow_busy[%0d] got=%b exp=1", j, busy_slow);
      end
      if (if_slow.ready !== (j == 43)) begin
        bad++; $display("FAIL slow_ready[%0d] got=%b exp=%b", j, if_slow.ready, (j == 43));
      end
      if (j == 15) begin
        if_slow.data  = 8'hFF;
        if_slow.valid = 1'b1;
      end else begin
        if_slow.valid = 1'b0;
      end
      @(negedge clk);
    end
    total++;
    if (busy_slow !== 1'b0) begin
      bad++; $display("FAIL slow_busy_end got=%b exp=0", busy_slow);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] exp;
    exp = {1'b1, 8'hA5, 1'b0};
    @(negedge clk);
    if_def.data  = 8'hA5;
    if_def.valid = 1'b1;
    @(negedge clk);
    if_def.valid = 1'b0;
    // Samples 0..4 cover start and data bits 0..3; reset goes low during data bit 3.
    for (int i = 0; i < 5; i++) begin
      total++;
      if (line_def !== exp[i]) begin
        bad++; $display("FAIL midrst_pre_line[%0d] got=%b exp=%b", i, line_def, exp[i]);
      end
      if (i == 4) reset = 1'b0;
      @(negedge clk);
    end
    total += 3;
    if (line_def !== 1'b1) begin
      bad++; $display("FAIL midrst_line got=%b exp=1", line_def);
    end
    if (busy_def !== 1'b0) begin
      bad++; $display("FAIL midrst_busy got=%b exp=0", busy_def);
    end
    if (if_def.ready !== 1'b1) begin
      bad++; $display("FAIL midrst_ready got=%b exp=1", if_def.ready);
    end
    reset = 1'b1;
    @(negedge clk);
    exp = {1'b1, 8'h3A, 1'b0};
    if_def.data  = 8'h3A;
    if_def.valid = 1'b1;
    @(negedge clk);
    if_def.valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (line_def !== exp[i]) begin
        bad++; $display("FAIL midrst_post_line[%0d] got=%b exp=%b", i, line_def, exp[i]);
      end
      @(negedge clk);
    end
    total++;
    if (busy_def !== 1'b0) begin
      bad++; $display("FAIL midrst_post_busy got=%b exp=0", busy_def);
    end
  endtask

  task automatic test_loopback;
    logic [7:0] words [4];
    logic [7:0] rx;
    int         waited;
    words[0] = 8'h00; words[1] = 8'h55; words[2] = 8'hAA; words[3] = 8'hFF;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      if_def.data  = words[w];
      if_def.valid = 1'b1;
      @(negedge clk);
      if_def.valid = 1'b0;
      waited = 0;
      while (line_def !== 1'b0 && waited < 4) begin
        @(negedge clk);
        waited++;
      end
      total++;
      if (waited >= 4) begin
        bad++; $display("FAIL loop_start[%0d] got=no_start exp=start_bit", w);
      end else begin
        for (int b = 0; b < 8; b++) begin
          @(negedge clk);
          rx[b] = line_def;
        end
        @(negedge clk);
        total += 2;
        if (line_def !== 1'b1) begin
          bad++; $display("FAIL loop_stop[%0d] got=%b exp=1", w, line_def);
        end
        if (rx !== words[w]) begin
          bad++; $display("FAIL loop_word[%0d] got=%h exp=%h", w, rx, words[w]);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    if_def.valid  = 1'b0; if_def.data  = '0;
    if_even.valid = 1'b0; if_even.data = '0;
    if_odd.valid  = 1'b0; if_odd.data  = '0;
    if_slow.valid = 1'b0; if_slow.data = '0;
    test_reset();
    test_default();
    test_parity();
    test_back_to_back();
    test_slow_ignore();
    test_reset_mid_frame();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
